// File: rtl/egress_reader.sv
// Round-robin VOQ reader: grant in T, rd_en/rd_sel in T+1, capture in T+2, out_valid in T+3.
// Reads stall once the 4-entry output FIFO cannot hold in-flight data; optional pkt_cnt under EGRESS_READER_CNT_EN.
module egress_reader #(
    parameter int  PORT_NUB   = 4,
    parameter int  DATA_WIDTH = 8,
    localparam int SEL_W      = $clog2(PORT_NUB)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PORT_NUB-1:0]   empty_in,
    output logic                  rd_en,
    output logic [SEL_W-1:0]      rd_sel,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]      out_src
`ifdef EGRESS_READER_CNT_EN
    ,
    output logic [15:0]           pkt_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                          state_q;
    logic [SEL_W-1:0]                rd_sel_q;
    logic                            rd_en_d_q;
    logic [SEL_W-1:0]                rd_sel_d_q;
    logic [SEL_W-1:0]                ptr_q;
    logic [2:0]                      count_q;
    logic [1:0]                      wr_ptr_q;
    logic [1:0]                      rd_ptr_q;
    logic [SEL_W+DATA_WIDTH-1:0]     mem_q [4];

    logic [PORT_NUB-1:0]             elig;
    logic                            gnt_vld;
    logic [SEL_W-1:0]                gnt_sel;
    logic [SEL_W-1:0]                scan_idx;
    logic [3:0]                      room_sum;
    logic                            has_room;
    logic                            push;
    logic                            pop;
    logic [2:0]                      count_d;
    logic [1:0]                      wr_ptr_d;
    logic [1:0]                      rd_ptr_d;

    // The READ state is exactly the cycle the registered read strobe is high.
    assign rd_en     = (state_q == READ);
    assign rd_sel    = rd_sel_q;
    assign out_valid = (count_q != 3'd0);
    assign out_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign out_src   = mem_q[rd_ptr_q][SEL_W+DATA_WIDTH-1:DATA_WIDTH];

    // A queue being read this cycle still looks non-empty, so mask it out.
    always_comb begin
        elig = '0;
        for (int k = 0; k < PORT_NUB; k++) begin
            elig[k] = !empty_in[k] && !(rd_en && (rd_sel_q == SEL_W'(k)));
        end
    end

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_sel  = '0;
        scan_idx = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            scan_idx = ptr_q + SEL_W'(i);
            if (!gnt_vld && elig[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_sel = scan_idx;
            end
        end
    end

    // Reserve a slot for every read still in flight; a same-cycle pop is not credited.
    assign room_sum = {1'b0, count_q} + {3'b000, rd_en} + {3'b000, rd_en_d_q} + 4'd1;
    assign has_room = (room_sum <= 4'd4);

    assign push     = rd_en_d_q;
    assign pop      = out_valid && out_ready;
    assign count_d  = count_q + {2'b00, push} - {2'b00, pop};
    assign wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_sel_q   <= '0;
            rd_en_d_q  <= 1'b0;
            rd_sel_d_q <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (gnt_vld && has_room) begin
                state_q  <= READ;
                rd_sel_q <= gnt_sel;
                ptr_q    <= gnt_sel + SEL_W'(1);
            end else if (gnt_vld) begin
                state_q  <= STALL;
            end else begin
                state_q  <= IDLE;
            end
            rd_en_d_q  <= rd_en;
            rd_sel_d_q <= rd_sel_q;
            if (push) begin
                mem_q[wr_ptr_q] <= {rd_sel_d_q, rd_data};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && (count_q == 3'd4)));
        end
    end

`ifdef EGRESS_READER_CNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_q + {15'd0, pop};
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_egress_reader.sv
// Directed bench for egress_reader with a behavioural VOQ model and an output accept log.
module tb_egress_reader;

    logic       clk;
    logic       rst_n;
    logic [3:0] empty_in;
    logic       rd_en;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_src;
`ifdef EGRESS_READER_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // VOQ model storage, read log and accepted-output log
    logic [7:0]  vmem [0:3][0:31];
    int          vhead [4];
    int          vtail [4];
    logic [7:0]  pend;
    int          voq_err = 0;
    logic [1:0]  sel_log [$];
    logic [15:0] acc_q [$];

    egress_reader #(.PORT_NUB(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .empty_in  (empty_in),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
`ifdef EGRESS_READER_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach summary (bad=%0d)", bad);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int k, input logic [7:0] w);
        vmem[k][vtail[k]] = w;
        vtail[k]++;
    endtask

    // VOQ: data returns one cycle after rd_en; empty flags reflect pops one cycle late
    initial begin
        rd_data  = '0;
        empty_in = '1;
        pend     = '0;
        for (int k = 0; k < 4; k++) begin
            vhead[k] = 0;
            vtail[k] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            rd_data = pend;
            for (int k = 0; k < 4; k++) begin
                empty_in[k] = (vhead[k] == vtail[k]);
            end
            if (rd_en) begin
                sel_log.push_back(rd_sel);
                if (vhead[rd_sel] == vtail[rd_sel]) begin
                    voq_err++;
                    pend = 8'hEE;
                end else begin
                    pend = vmem[rd_sel][vhead[rd_sel]];
                    vhead[rd_sel]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                acc_q.push_back({6'd0, out_src, out_data});
            end
        end
    end

    initial begin
        int          exp_sel [5];
        logic [15:0] exp_acc [5];
        logic        e_en [7];
        logic [15:0] o16;
        logic [15:0] e16;
        int          k;
        int          idx;

        exp_sel = '{0, 1, 2, 3, 0};
        exp_acc = '{16'h0010, 16'h0111, 16'h0212, 16'h0313, 16'h0014};
        e_en    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        rst_n     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_sel", 32'(rd_sel), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        rst_n = 1'b1;
        tick();

        // A: single word in queue 2
        sel_log.delete();
        acc_q.delete();
        load(2, 8'hA5);
        tick();
        check("A_rd_en_n1", 32'(rd_en), 32'd0);
        tick();
        check("A_rd_en_n2", 32'(rd_en), 32'd1);
        check("A_rd_sel_n2", 32'(rd_sel), 32'd2);
        tick();
        check("A_rd_en_n3", 32'(rd_en), 32'd0);
        check("A_out_valid_n3", 32'(out_valid), 32'd0);
        tick();
        check("A_out_valid_n4", 32'(out_valid), 32'd1);
        check("A_out_data_n4", 32'(out_data), 32'hA5);
        check("A_out_src_n4", 32'(out_src), 32'd2);
        tick();
        check("A_out_valid_n5", 32'(out_valid), 32'd0);
        repeat (4) tick();
        check("A_reads", 32'(sel_log.size()), 32'd1);

        // B: all queues non-empty from ptr=0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        sel_log.delete();
        acc_q.delete();
        load(0, 8'h10);
        load(0, 8'h14);
        load(1, 8'h11);
        load(2, 8'h12);
        load(3, 8'h13);
        tick();
        check("B_rd_en_n1", 32'(rd_en), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("B_rd_en", 32'(rd_en), 32'd1);
            check("B_rd_sel", 32'(rd_sel), 32'(exp_sel[i]));
        end
        tick();
        check("B_rd_en_end", 32'(rd_en), 32'd0);
        repeat (5) tick();
        check("B_acc_count", 32'(acc_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            o16 = (i < acc_q.size()) ? acc_q[i] : 16'hFFFF;
            check("B_acc_word", 32'(o16), 32'(exp_acc[i]));
        end

        // C: single queue with three words reads every other cycle
        sel_log.delete();
        acc_q.delete();
        load(1, 8'h31);
        load(1, 8'h32);
        load(1, 8'h33);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("C_rd_en", 32'(rd_en), 32'(e_en[i]));
            if (e_en[i]) begin
                check("C_rd_sel", 32'(rd_sel), 32'd1);
            end
        end
        repeat (4) tick();
        check("C_acc_count", 32'(acc_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            o16 = (i < acc_q.size()) ? acc_q[i] : 16'hFFFF;
            check("C_acc_word", 32'(o16), 32'h0131 + 32'(i));
        end

        // D: backpressure with all queues holding three words, ptr=2
        sel_log.delete();
        acc_q.delete();
        out_ready = 1'b0;
        for (int q = 0; q < 4; q++) begin
            for (int w = 0; w < 3; w++) begin
                load(q, 8'(q * 16 + w));
            end
        end
        repeat (6) tick();
        check("D_reads_stalled", 32'(sel_log.size()), 32'd4);
        check("D_state_stall", 32'(dut.state_q), 32'd2);
        check("D_rd_en_n6", 32'(rd_en), 32'd0);
        check("D_out_data_n6", 32'(out_data), 32'h20);
        repeat (3) tick();
        check("D_reads_hold", 32'(sel_log.size()), 32'd4);
        check("D_state_hold", 32'(dut.state_q), 32'd2);
        check("D_out_valid_hold", 32'(out_valid), 32'd1);
        check("D_out_data_hold", 32'(out_data), 32'h20);
        check("D_out_src_hold", 32'(out_src), 32'd2);
        tick();
        out_ready = 1'b1;
        check("D_pop0", 32'(out_data), 32'h20);
        tick();
        check("D_pop1", 32'(out_data), 32'h30);
        check("D_pop1_src", 32'(out_src), 32'd3);
        tick();
        check("D_pop2", 32'(out_data), 32'h00);
        check("D_resume", 32'(sel_log.size()), 32'd5);
        tick();
        check("D_pop3", 32'(out_data), 32'h10);
        check("D_pop3_src", 32'(out_src), 32'd1);
        repeat (30) tick();
        check("D_reads_total", 32'(sel_log.size()), 32'd12);
        check("D_acc_count", 32'(acc_q.size()), 32'd12);
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 4; j++) begin
                k   = (2 + j) % 4;
                idx = w * 4 + j;
                e16 = {6'd0, 2'(k), 8'(k * 16 + w)};
                o16 = (idx < acc_q.size()) ? acc_q[idx] : 16'hFFFF;
                check("D_acc_order", 32'(o16), 32'(e16));
            end
        end

        // E: reset while a read is in flight and two words are buffered
        sel_log.delete();
        acc_q.delete();
        out_ready = 1'b0;
        for (int q = 0; q < 4; q++) begin
            load(q, 8'(8'hE0 + q));
        end
        repeat (5) tick();
        check("E_rd_en_before", 32'(rd_en), 32'd1);
        check("E_out_valid_before", 32'(out_valid), 32'd1);
        check("E_reads_before", 32'(sel_log.size()), 32'd4);
        rst_n = 1'b0;
        tick();
        check("E_out_valid_after", 32'(out_valid), 32'd0);
        check("E_rd_en_after", 32'(rd_en), 32'd0);
        check("E_out_data_after", 32'(out_data), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) tick();
        check("E_no_output", 32'(acc_q.size()), 32'd0);
        check("E_out_valid_idle", 32'(out_valid), 32'd0);
        check("E_reads_total", 32'(sel_log.size()), 32'd4);
        check("voq_underrun", 32'(voq_err), 32'd0);

`ifdef EGRESS_READER_CNT_EN
        // F: accepted-word counter
        rst_n = 1'b0;
        tick();
        check("F_cnt_reset", 32'(pkt_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        load(0, 8'h50);
        load(0, 8'h51);
        load(1, 8'h52);
        load(2, 8'h53);
        load(3, 8'h54);
        repeat (15) tick();
        check("F_cnt_five", 32'(pkt_cnt), 32'd5);
        force dut.pkt_cnt_q = 16'hFFFF;
        tick();
        release dut.pkt_cnt_q;
        tick();
        check("F_cnt_preload", 32'(pkt_cnt), 32'hFFFF);
        load(0, 8'h55);
        repeat (8) tick();
        check("F_cnt_wrap", 32'(pkt_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/egress_reader.md
EGRESS_READER -- requirements
Module: egress_reader

Interface
REQ-001 The block SHALL have the parameter PORT_NUB, default 4, giving the number of source queues per output port (power of two, at least 2).
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-003 The block SHALL define SEL_W as $clog2(PORT_NUB).
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 empty_in  input  PORT_NUB  bit k high means source queue k of this output's VOQ is empty.
REQ-007 rd_en  output  1  VOQ read strobe, registered.
REQ-008 rd_sel  output  SEL_W  source queue being read, registered, valid while rd_en is high.
REQ-009 rd_data  input  DATA_WIDTH  VOQ read data, valid exactly one cycle after rd_en.
REQ-010 out_valid  output  1  out_data and out_src are valid.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-012 out_data  output  DATA_WIDTH  payload at the head of the output buffer.
REQ-013 out_src  output  SEL_W  source port of out_data.

Function
REQ-014 The block SHALL drain a 4-entry FIFO of {src, data} words and present its head on out_data, out_src and out_valid; out_valid SHALL be high if and only if the FIFO is non-empty.
REQ-015 Queue k SHALL be eligible when empty_in[k] is 0 and it is not the queue being read this cycle (rd_en high with rd_sel equal to k).
REQ-016 The block SHALL issue a read only when count + rd_en + rd_en_d + 1 <= 4, where rd_en_d is rd_en delayed by one cycle; a pop in the same cycle SHALL NOT be credited.
REQ-017 Arbitration SHALL be round-robin: starting from pointer ptr and searching upward modulo PORT_NUB, the block SHALL grant the first eligible queue, and on a grant SHALL set ptr to grant+1 (mod PORT_NUB).
REQ-018 Timing: a grant decided in cycle T SHALL drive rd_en and rd_sel in T+1; rd_data SHALL be captured at the end of T+2 together with the delayed rd_sel; out_valid SHALL rise in T+3 if the FIFO was empty.
REQ-019 The block SHALL have the internal states IDLE (no eligible queue), READ (grant issued), and STALL (an eligible queue exists but the room check fails).
REQ-020 The block SHALL move to READ from any state when a queue is eligible and room exists, to STALL when a queue is eligible and no room exists, and otherwise to IDLE.
REQ-021 A simultaneous push and pop SHALL leave count unchanged; a push when count is 4 SHALL NOT occur by construction, and an assertion SHALL flag it.
REQ-022 Sustained throughput SHALL be 1 word per cycle when at least 2 queues are non-empty and out_ready is held high.
REQ-023 With a single non-empty queue, the block SHALL read that queue at most every other cycle because of the masking in REQ-015.
REQ-024 The FIFO read and write pointers SHALL be 2 bits wide and wrap from 3 to 0.
REQ-025 out_data and out_src SHALL remain stable while out_valid is high and out_ready is low.

Reset
REQ-026 While rst_n is 0 at a clock edge, the block SHALL set rd_en=0, rd_sel=0, out_valid=0, out_data=0, out_src=0, ptr=0, count=0, rd_en_d=0 and state=IDLE.
REQ-027 A reset during operation SHALL discard the FIFO contents and any in-flight read; rd_data arriving in the cycle after reset SHALL NOT be captured.

Configuration
REQ-028 When EGRESS_READER_CNT_EN is defined, the block SHALL add the output pkt_cnt [15:0], which increments on every accepted output word (out_valid and out_ready both high), wraps from 0xFFFF to 0, and resets to 0.
REQ-029 When EGRESS_READER_CNT_EN is not defined, the pkt_cnt port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (PORT_NUB=4, DATA_WIDTH=8)
REQ-030 Queue 2 holds one word 0xA5 and out_ready=1 -> rd_en with rd_sel=2 one cycle after empty_in[2] falls; out_valid with out_data=0xA5 and out_src=2 three cycles after; exactly one read.
REQ-031 All 4 queues are non-empty, ptr=0 and out_ready=1 -> rd_sel sequence 0,1,2,3,0, one read per cycle; out_src matches that order.
REQ-032 out_ready is held 0 with all queues non-empty -> exactly 4 reads are issued, state=STALL, out_data stable; when out_ready rises, 4 words pop in 4 cycles and reads resume.
REQ-033 Only queue 1 holds 3 words -> rd_en pattern 1,0,1,0,1 with rd_sel=1, and all 3 words are delivered in order.
REQ-034 rst_n is pulsed for one cycle while a read is in flight and 2 words are buffered -> out_valid=0 next cycle and the in-flight data is never output.
REQ-035 EGRESS_READER_CNT_EN is defined and 5 words are accepted -> pkt_cnt=5; with pkt_cnt preloaded to 0xFFFF, one accept -> pkt_cnt=0.
